// File: rtl/sr_latch_driver.sv
// sr_latch_driver: valid/ready command front-end that pulses S or R of a NOR SR latch,
// waits a dead-time gap, then confirms Q feedback with done or timeout err.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s_out,
    output logic r_out,
    input  logic q_fb,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_q, cmd_d;
    logic             s_q, s_d, r_q, r_d;
    logic             done_q, done_d, err_q, err_d;
    logic             accept;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign busy      = state_q != IDLE;
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign err       = err_q;

    // s_d and r_d are only ever set as a complementary pair, so S=R=1 cannot be registered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    cmd_d   = req_set;
                    s_d     = req_set;
                    r_d     = ~req_set;
                end
            end
            PULSE: begin
                if (cnt_q == P_LAST) begin
                    state_d = (GAP_W == 0) ? CHECK : GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    s_d   = cmd_q;
                    r_d   = ~cmd_q;
                end
            end
            GAP: begin
                state_d = (cnt_q == G_LAST) ? CHECK : GAP;
                cnt_d   = (cnt_q == G_LAST) ? '0 : cnt_q + 1'b1;
            end
            CHECK: begin
                if (q_fb == cmd_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q == T_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed checks of the SR latch driver with a simple latch model,
// plus a second instance at PULSE_W=1, GAP_W=0, TIMEOUT=1.
module tb_sr_latch_driver;
    logic clk = 1'b0;
    logic rst_n, req_valid, req_set, req_ready, s_out, r_out, busy, done, err;
    logic valid2, set2, ready2, s2, r2, q2, busy2, done2, err2;
    logic q_model = 1'b0;
    logic stuck = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // NOR latch model: S sets, R clears; stuck pins Q low to force a timeout
    always @(posedge clk) q_model <= stuck ? 1'b0 : s_out ? 1'b1 : r_out ? 1'b0 : q_model;

    sr_latch_driver dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_set(req_set),
        .req_ready(req_ready), .s_out(s_out), .r_out(r_out), .q_fb(q_model),
        .busy(busy), .done(done), .err(err)
    );

    sr_latch_driver #(.PULSE_W(1), .GAP_W(0), .TIMEOUT(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_set(set2),
        .req_ready(ready2), .s_out(s2), .r_out(r2), .q_fb(q2),
        .busy(busy2), .done(done2), .err(err2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        checks++;
        assert (!(s_out && r_out) && !(s2 && r2) && !(done && err) && !(done2 && err2)) else begin
            errors++;
            $error("FAIL invariant observed s=%b r=%b d=%b e=%b s2=%b r2=%b expected no overlap",
                   s_out, r_out, done, err, s2, r2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_set = 1'b0;
        valid2 = 1'b0; set2 = 1'b0; q2 = 1'b0;
        step(2);
        chk("rst_s", s_out, 1'b0); chk("rst_r", r_out, 1'b0);
        chk("rst_done", done, 1'b0); chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0); chk("rst_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk("idle_ready", req_ready, 1'b1); chk("idle_busy", busy, 1'b0);

        // set command
        req_valid = 1'b1; req_set = 1'b1;
        step(1);
        chk("set_s0", s_out, 1'b1); chk("set_r0", r_out, 1'b0);
        chk("set_busy", busy, 1'b1); chk("set_ready", req_ready, 1'b0);
        req_valid = 1'b0;
        step(1);
        chk("set_s1", s_out, 1'b1); chk("set_r1", r_out, 1'b0);
        step(1);
        chk("set_gap_s", s_out, 1'b0); chk("set_gap_r", r_out, 1'b0);
        step(1);
        chk("set_chk_done", done, 1'b0); chk("set_chk_busy", busy, 1'b1);
        step(1);
        chk("set_done", done, 1'b1); chk("set_err", err, 1'b0);
        chk("set_done_ready", req_ready, 1'b1); chk("set_done_busy", busy, 1'b0);
        step(1);
        chk("set_done_end", done, 1'b0);

        // reset command from Q=1
        req_valid = 1'b1; req_set = 1'b0;
        step(1);
        chk("rcmd_r0", r_out, 1'b1); chk("rcmd_s0", s_out, 1'b0);
        req_valid = 1'b0;
        step(1);
        chk("rcmd_r1", r_out, 1'b1); chk("rcmd_s1", s_out, 1'b0);
        step(1);
        chk("rcmd_gap_r", r_out, 1'b0);
        step(2);
        chk("rcmd_done", done, 1'b1); chk("rcmd_err", err, 1'b0);
        chk("rcmd_q", q_model, 1'b0);
        step(1);
        chk("rcmd_done_end", done, 1'b0);

        // timeout with Q stuck low
        stuck = 1'b1;
        req_valid = 1'b1; req_set = 1'b1;
        step(1);
        chk("to_s", s_out, 1'b1);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("to_no_err", err, 1'b0); chk("to_no_done", done, 1'b0);
        end
        step(1);
        chk("to_err", err, 1'b1); chk("to_done", done, 1'b0);
        chk("to_ready", req_ready, 1'b1);
        step(1);
        chk("to_err_end", err, 1'b0); chk("to_idle", busy, 1'b0);
        stuck = 1'b0;

        // back-to-back 1,0,1 with req_valid held; req_set change while busy is ignored
        req_valid = 1'b1; req_set = 1'b1;
        step(1);
        chk("b2b1_s", s_out, 1'b1);
        req_set = 1'b0;
        step(1);
        chk("b2b1_ignore_s", s_out, 1'b1); chk("b2b1_ignore_r", r_out, 1'b0);
        step(3);
        chk("b2b1_done", done, 1'b1); chk("b2b1_ready", req_ready, 1'b1);
        step(1);
        chk("b2b2_r", r_out, 1'b1); chk("b2b2_s", s_out, 1'b0);
        chk("b2b2_busy", busy, 1'b1); chk("b2b2_done_end", done, 1'b0);
        step(4);
        chk("b2b2_done", done, 1'b1); chk("b2b2_err", err, 1'b0);
        req_set = 1'b1;
        step(1);
        chk("b2b3_s", s_out, 1'b1); chk("b2b3_r", r_out, 1'b0);
        step(4);
        chk("b2b3_done", done, 1'b1);
        req_valid = 1'b0;
        step(1);
        chk("b2b3_idle", busy, 1'b0); chk("b2b3_s_idle", s_out, 1'b0);

        // asynchronous reset during the second pulse cycle
        req_valid = 1'b1; req_set = 1'b1;
        step(1);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_s_before", s_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_s_async", s_out, 1'b0); chk("mid_r_async", r_out, 1'b0);
        chk("mid_busy", busy, 1'b0); chk("mid_ready", req_ready, 1'b0);
        step(2);
        chk("mid_no_done", done, 1'b0); chk("mid_no_err", err, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("mid_ready_after", req_ready, 1'b1);
        req_valid = 1'b1; req_set = 1'b0;
        step(1);
        chk("post_r", r_out, 1'b1);
        req_valid = 1'b0;
        step(4);
        chk("post_done", done, 1'b1); chk("post_err", err, 1'b0);
        step(1);

        // PULSE_W=1, GAP_W=0, TIMEOUT=1 instance: mismatch then match
        valid2 = 1'b1; set2 = 1'b1;
        step(1);
        chk("p2_s", s2, 1'b1); chk("p2_busy", busy2, 1'b1);
        valid2 = 1'b0;
        step(1);
        chk("p2_s_end", s2, 1'b0); chk("p2_check_busy", busy2, 1'b1);
        chk("p2_no_err_yet", err2, 1'b0);
        step(1);
        chk("p2_err", err2, 1'b1); chk("p2_no_done", done2, 1'b0);
        chk("p2_ready", ready2, 1'b1);
        step(1);
        chk("p2_err_end", err2, 1'b0);
        q2 = 1'b1;
        valid2 = 1'b1; set2 = 1'b1;
        step(1);
        chk("p2m_s", s2, 1'b1);
        valid2 = 1'b0;
        step(1);
        chk("p2m_s_end", s2, 1'b0);
        step(1);
        chk("p2m_done", done2, 1'b1); chk("p2m_err", err2, 1'b0);
        step(1);
        chk("p2m_done_end", done2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked command front-end that drives the S/R inputs of a NOR-based SR latch.
- Accepts set/reset commands over a valid/ready handshake and emits a single S or R pulse of programmable width, followed by a dead-time gap.
- Checks the latch's Q feedback and reports done or timeout error.
- Guarantees the forbidden S=R=1 condition is never driven onto the latch.

Parameters:
- PULSE_W, 2, width of the S or R pulse in clk cycles; legal range is 1 or more.
- GAP_W, 1, dead-time cycles with S=R=0 after the pulse; 0 skips the GAP state.
- TIMEOUT, 8, number of CHECK sample edges allowed for q_fb to match; legal range is 1 or more.
- CNT_W, 4, shared counter width; must hold max(PULSE_W, GAP_W, TIMEOUT).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  command present.
- req_set  input  1  command type: 1 = set (drive S), 0 = reset (drive R); sampled only at handshake.
- req_ready  output  1  driver can accept a command.
- s_out  output  1  to latch S input; registered.
- r_out  output  1  to latch R input; registered.
- q_fb  input  1  latch Q output, synchronous to clk.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: latch confirmed in the commanded state.
- err  output  1  one-cycle pulse: timeout, q_fb never matched.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; counter and stored command are cleared.
  - s_out=0, r_out=0, done=0, err=0, busy=0.
  - req_ready is forced 0 while rst_n is low.
- req_ready = (state==IDLE) && rst_n. It is a combinational decode of registered state.
- Handshake:
  - A command is accepted on a rising edge where req_valid && req_ready.
  - req_set is captured into cmd at that edge. No backpressure on outputs.
- FSM states: IDLE, PULSE, GAP, CHECK.
  - IDLE: on accept -> PULSE, counter=0. Registered s_out=cmd and r_out=~cmd take effect from this same edge.
  - PULSE: the pulse stays high for exactly PULSE_W cycles. At the edge ending the PULSE_W-th cycle, s_out=r_out=0, and state -> GAP (or -> CHECK if GAP_W=0); counter=0.
  - GAP: S=R=0 for GAP_W cycles, then -> CHECK; counter=0.
  - CHECK: q_fb is sampled at each rising edge.
    - If q_fb==cmd: done=1 for the next cycle, state -> IDLE.
    - Otherwise counter increments. On the TIMEOUT-th non-matching sample: err=1 for the next cycle, state -> IDLE.
- done and err are never high together, and each is high for exactly 1 cycle.
- Latency with defaults, immediate match:
  - Accept at edge 0; s_out high between edge 0 and edge 2.
  - GAP between edge 2 and edge 3.
  - q_fb sampled at edge 4; done high between edge 4 and edge 5.
- A pulse is always issued, even if q_fb already equals cmd at acceptance; there is no skip.
- Invariant: s_out && r_out is 0 in every cycle, including reset and mid-operation.
- Back-to-back commands:
  - req_ready is 1 in the same cycle that done or err is high.
  - A new command is accepted at the edge that ends that cycle, and its pulse starts immediately.
- req_valid and req_set changes while busy are ignored; no queuing.
- Reset mid-operation (any state): the outputs go to 0 immediately and asynchronously, and the command is dropped. No done or err is issued. After rst_n rises, the block is in IDLE with req_ready=1.
- The counter saturates at its terminal value and never wraps within a state.

Test Plan:
- Set command: rst_n released, req_valid=1, req_set=1 for one cycle; the latch model sets Q on S.
  - Required: s_out=1 for 2 cycles, r_out=0 throughout, then 1 gap cycle, then done=1 exactly 4 cycles after acceptance, busy=0 after.
- Reset command from Q=1: req_set=0.
  - Required: r_out=1 for 2 cycles, s_out stays 0, q_fb falls, then done pulse; err stays 0.
- Timeout: the latch model holds q_fb=0, req_set=1.
  - Required: 8 non-matching CHECK samples, then err=1 for 1 cycle; done never asserted; req_ready=1 in the err cycle.
- Back-to-back: req_valid held 1, alternating req_set 1,0,1.
  - Required: three accepts with no idle cycle between done and the next pulse start.
  - s_out && r_out never 1; checked by an assertion every cycle.
- Reset mid-pulse: rst_n=0 asynchronously during the second PULSE cycle with s_out=1.
  - Required: s_out=0 immediately, busy=0, no done or err.
  - After release, a new command completes normally.
- Parameter sweep: PULSE_W=1, GAP_W=0, TIMEOUT=1.
  - Required: pulse is 1 cycle; CHECK follows directly; a single mismatch produces err on the next cycle.
